// File: rtl/alu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default widths,
// opcode values and the controller state encoding.
package alu_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned CNT_W_DEF = 5;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // 2'd3 is never entered; the controller treats it exactly like IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit ripple-carry adder built from single-bit full-adder cells.
// Subtraction is a + ~b with cin_i = 1, with the inversion done by the caller.
module alu_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module alu_addsub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin_i;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      alu_fa u_fa (
         .a_i (a_i[i]),
         .b_i (b_i[i]),
         .c_i (carry[i]),
         .s_o (sum_o[i]),
         .c_o (carry[i+1])
      );
   end

   assign cout_o = carry[WIDTH];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one
// adder step per clock, with valid/ready handshakes on request and result.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dbz
);

   state_e           state_q;
   logic             op_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             dbz_q;

   logic [WIDTH-1:0] rem_shift;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_cout;
   logic             no_borrow;
   logic             last_step;

   assign in_ready  = !rst && (state_q != RUN) && (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbz       = dbz_q;

   // DIV: remainder shifted left, pulling in the next dividend bit.
   assign rem_shift = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};

   always_comb begin
      add_a   = acc_hi_q;
      add_b   = acc_lo_q[0] ? b_q : '0;
      add_cin = 1'b0;
      if (op_q == OP_DIV) begin
         add_a   = rem_shift;
         add_b   = ~b_q;
         add_cin = 1'b1;
      end
   end

   alu_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // The bit shifted out of the remainder is the (WIDTH+1)th bit of the trial
   // subtraction; if it is set the trial can never borrow.
   assign no_borrow = acc_hi_q[WIDTH-1] | add_cout;

   always_comb begin
      acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
      acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
      if (op_q == OP_DIV) begin
         acc_hi_d = no_borrow ? add_sum : rem_shift;
         acc_lo_d = {acc_lo_q[WIDTH-2:0], no_borrow};
      end
   end

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               acc_hi_q <= acc_hi_d;
               acc_lo_q <= acc_lo_d;
               if (last_step) begin
                  state_q <= DONE;
                  hi_q    <= acc_hi_d;
                  lo_q    <= acc_lo_d;
                  dbz_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               if (in_valid) begin
                  op_q     <= op;
                  b_q      <= b;
                  acc_hi_q <= '0;
                  acc_lo_q <= a;
                  cnt_q    <= '0;
                  if ((op == OP_DIV) && (b == '0)) begin
                     state_q <= DONE;
                     hi_q    <= a;
                     lo_q    <= '1;
                     dbz_q   <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: expected results are queued at issue
// time from a behavioural a*b, a/b, a%b model and popped when out_valid rises.
module tb_alu_muldiv_seq;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] hi, lo;
   logic         dbz;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_muldiv_seq #(
      .WIDTH (W),
      .CNT_W (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hi        (hi),
      .lo        (lo),
      .dbz       (dbz)
   );

   // Drive a request from a negedge, push its expected result, wait for the
   // accept edge, then scramble the operands. Returns at the negedge after accept.
   task automatic issue(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb);
      exp_t        e;
      logic [31:0] p;
      bit          acc;
      if (o == 1'b0) begin
         p     = {16'h0, aa} * {16'h0, bb};
         e.hi  = p[31:16];
         e.lo  = p[15:0];
         e.dbz = 1'b0;
      end else if (bb == 0) begin
         e.hi  = aa;
         e.lo  = 16'hFFFF;
         e.dbz = 1'b1;
      end else begin
         e.hi  = aa % bb;
         e.lo  = aa / bb;
         e.dbz = 1'b0;
      end
      sb.push_back(e);
      op       = o;
      a        = aa;
      b        = bb;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int i = 0; i < 100 && !acc; i++) begin
         if (in_ready) begin
            @(posedge clk);
            acc = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      op       = ~o;
      a        = ~aa;
      b        = ~bb;
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready never high, required accept within 100 cycles");
      end
   endtask

   // Count cycles from accept (accept edge = 1) until out_valid is seen.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         n_cmp++;
         n_fail++;
         $display("FAIL result_timeout: out_valid=0 after %0d cycles, required 1", lat);
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, hi, lo, dbz} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b vld=%b hi=%h lo=%h dbz=%b, required all 0",
                  in_ready, out_valid, hi, lo, dbz);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_mul_max();
      exp_t e;
      int   lat;
      issue(1'b0, 16'hFFFF, 16'hFFFF);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL mul_latency: got %0d, required 17", lat);
      end
      n_cmp++;
      if ({hi, lo, dbz} !== {16'hFFFE, 16'h0001, 1'b0} || {hi, lo, dbz} !== {e.hi, e.lo, e.dbz}) begin
         n_fail++;
         $display("FAIL mul_ffff: got hi=%h lo=%h dbz=%b, required hi=fffe lo=0001 dbz=0", hi, lo, dbz);
      end
      consume();
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL mul_consume: got vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_div();
      exp_t        e;
      int          lat;
      logic [15:0] da[2];
      logic [15:0] db[2];
      da[0] = 16'd100;  db[0] = 16'd7;
      da[1] = 16'hFFFF; db[1] = 16'h8001;
      for (int i = 0; i < 2; i++) begin
         issue(1'b1, da[i], db[i]);
         wait_out(lat);
         e = sb.pop_front();
         n_cmp++;
         if ({hi, lo, dbz, lat} !== {e.hi, e.lo, e.dbz, 32'd17}) begin
            n_fail++;
            $display("FAIL div_%0d: got hi=%h lo=%h dbz=%b lat=%0d, required hi=%h lo=%h dbz=%b lat=17",
                     i, hi, lo, dbz, lat, e.hi, e.lo, e.dbz);
         end
         consume();
      end
   endtask

   task automatic test_dbz();
      exp_t e;
      int   lat;
      issue(1'b1, 16'h1234, 16'h0000);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL dbz_latency: got %0d, required 1", lat);
      end
      n_cmp++;
      if ({hi, lo, dbz} !== {16'h1234, 16'hFFFF, 1'b1} || {hi, lo, dbz} !== {e.hi, e.lo, e.dbz}) begin
         n_fail++;
         $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b, required hi=1234 lo=ffff dbz=1", hi, lo, dbz);
      end
      consume();
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      issue(1'b0, 16'd3, 16'd5);
      wait_out(lat);
      e = sb.pop_front();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if ({out_valid, in_ready, hi, lo, dbz} !== {1'b1, 1'b0, e.hi, e.lo, e.dbz}) begin
            n_fail++;
            $display("FAIL backpressure_%0d: got vld=%b rdy=%b hi=%h lo=%h, required vld=1 rdy=0 hi=0000 lo=000f",
                     i, out_valid, in_ready, hi, lo);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      consume();
   endtask

   task automatic test_reset_midrun();
      exp_t e;
      int   lat;
      issue(1'b0, 16'h1234, 16'h5678);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      void'(sb.pop_back());
      n_cmp++;
      if ({out_valid, in_ready, hi, lo, dbz} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_midrun: got vld=%b rdy=%b hi=%h lo=%h dbz=%b, required all 0",
                  out_valid, in_ready, hi, lo, dbz);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(1'b0, 16'd2, 16'd3);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++;
      if ({hi, lo, dbz, lat} !== {16'h0, 16'd6, 1'b0, 32'd17} || lo !== e.lo) begin
         n_fail++;
         $display("FAIL after_reset_mul: got hi=%h lo=%h lat=%0d, required hi=0000 lo=0006 lat=17", hi, lo, lat);
      end
      consume();
   endtask

   task automatic test_random();
      exp_t        e;
      int          lat;
      bit          done;
      logic        o;
      logic [15:0] aa, bb;
      for (int n = 0; n < 1000; n++) begin
         o  = 1'($urandom_range(0, 1));
         aa = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       bb = 16'h0;
            1:       bb = 16'($urandom_range(1, 15));
            2:       bb = 16'hFFFF;
            default: bb = 16'($urandom);
         endcase
         issue(o, aa, bb);
         wait_out(lat);
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL random_sb_empty: op %0d had no queued expectation", n);
            continue;
         end
         e    = sb.pop_front();
         done = 1'b0;
         for (int k = 0; k < 50 && !done; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready && out_valid) begin
               n_cmp++;
               if ({hi, lo, dbz} !== {e.hi, e.lo, e.dbz}) begin
                  n_fail++;
                  $display("FAIL random_%0d op=%b a=%h b=%h: got hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                           n, o, aa, bb, hi, lo, dbz, e.hi, e.lo, e.dbz);
               end
               done = 1'b1;
            end
            @(negedge clk);
         end
         out_ready = 1'b0;
         if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL random_consume_%0d: result never consumed, vld=%b required 1", n, out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_max();
      test_div();
      test_dbz();
      test_backpressure();
      test_reset_midrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
